// File: rtl/wb_mem_preloader.sv
// Wishbone-master memory preloader: writes a stream of (address, data) words into memory,
// then releases N_RST reset channels one after another with a configurable stagger.
module wb_mem_preloader #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int N_RST    = 2,
   parameter int RST_HOLD = 50,
   parameter int STAGGER  = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              load_en_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [AW-1:0]     s_addr_i,
   input  logic [DW-1:0]     s_data_i,
   input  logic              s_last_i,
   output logic [AW-1:0]     wbm_adr_o,
   output logic [DW-1:0]     wbm_dat_o,
   output logic [DW/8-1:0]   wbm_sel_o,
   output logic              wbm_we_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic [2:0]        wbm_cti_o,
   output logic [1:0]        wbm_bte_o,
   input  logic              wbm_ack_i,
   input  logic              wbm_err_i,
   output logic [N_RST-1:0]  rst_o,
   output logic              done_o,
   output logic              err_o,
   output logic [31:0]       word_cnt_o
);

   localparam int SW       = DW / 8;
   localparam int AL       = $clog2(SW);
   localparam int HOLD_MAX = RST_HOLD + (N_RST - 1) * STAGGER;
   localparam int HW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam int TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [AW-1:0] ADR_MASK = ~(AW'((1 << AL) - 1));

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_HOLD  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             act_q, act_d;
   logic             last_q, last_d;
   logic [AW-1:0]    adr_q, adr_d;
   logic [DW-1:0]    dat_q, dat_d;
   logic [SW-1:0]    sel_q, sel_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [N_RST-1:0] rst_q, rst_d;
   logic             ready_s;
   logic             tmo_hit_s;

   assign ready_s   = (state_q == ST_IDLE) && load_en_i && !wb_rst_i;
   // tmo_q counts completed stb cycles, so the TIMEOUT-th stb cycle is the last one
   assign tmo_hit_s = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

   // next-state logic for the load sequencer, bus master and reset stagger
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      last_d  = last_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (ready_s && s_valid_i) begin
               state_d = ST_WRITE;
               act_d   = 1'b1;
               adr_d   = s_addr_i & ADR_MASK;
               dat_d   = s_data_i;
               sel_d   = {SW{1'b1}};
               last_d  = s_last_i;
               tmo_d   = '0;
            end else if (!load_en_i) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (wbm_err_i || tmo_hit_s) begin
               state_d = ST_ERROR;
               act_d   = 1'b0;
               err_d   = 1'b1;
            end else if (wbm_ack_i) begin
               act_d   = 1'b0;
               cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
               hold_d  = '0;
               state_d = last_q ? ST_HOLD : ST_IDLE;
            end else begin
               tmo_d   = tmo_q + TW'(1);
            end
         end
         ST_HOLD: begin
            if (hold_q == HW'(HOLD_MAX)) begin
               state_d = ST_DONE;
            end else begin
               hold_d  = hold_q + HW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_ERROR;
            act_d   = 1'b0;
            err_d   = 1'b1;
         end
      endcase

      // resets are registered from the next state so rst_o[0] can drop on the first HOLD cycle
      for (int k = 0; k < N_RST; k++) begin
         if (state_d == ST_DONE) begin
            rst_d[k] = 1'b0;
         end else if (state_d == ST_HOLD) begin
            rst_d[k] = !(hold_d >= HW'(RST_HOLD + k * STAGGER));
         end else begin
            rst_d[k] = 1'b1;
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         act_q   <= 1'b0;
         last_q  <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= 32'd0;
         hold_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         rst_q   <= {N_RST{1'b1}};
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         last_q  <= last_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         rst_q   <= rst_d;
      end
   end

   assign s_ready_o  = ready_s;
   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = dat_q;
   assign wbm_sel_o  = sel_q;
   assign wbm_we_o   = act_q;
   assign wbm_cyc_o  = act_q;
   assign wbm_stb_o  = act_q;
   assign wbm_cti_o  = 3'b000;
   assign wbm_bte_o  = 2'b00;
   assign rst_o      = rst_q;
   assign done_o     = (state_q == ST_DONE);
   assign err_o      = err_q;
   assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_mem_preloader.sv
// Scoreboard bench for wb_mem_preloader: directed streams, zero-wait slave models,
// error/timeout/reset cases, plus a DW=64 instance.
module tb_wb_mem_preloader;

   typedef struct packed {
      logic [31:0] adr;
      logic [63:0] dat;
      logic [7:0]  sel;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   exp_t exp_q[$];
   exp_t exp64_q[$];

   // ---------------- DW=32 instance ----------------
   logic        wb_rst = 1'b1;
   logic        load_en = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_addr = 32'd0;
   logic [31:0] s_data = 32'd0;
   logic        s_last = 1'b0;
   logic [31:0] wbm_adr;
   logic [31:0] wbm_dat;
   logic [3:0]  wbm_sel;
   logic        wbm_we, wbm_cyc, wbm_stb;
   logic [2:0]  wbm_cti;
   logic [1:0]  wbm_bte;
   logic        wbm_ack = 1'b0;
   logic        wbm_err = 1'b0;
   logic [1:0]  rst_o;
   logic        done, err_o;
   logic [31:0] wcnt;

   wb_mem_preloader #(.DW(32), .AW(32), .N_RST(2), .RST_HOLD(50), .STAGGER(4), .TIMEOUT(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst), .load_en_i(load_en),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_addr_i(s_addr), .s_data_i(s_data), .s_last_i(s_last),
      .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
      .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
      .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err),
      .rst_o(rst_o), .done_o(done), .err_o(err_o), .word_cnt_o(wcnt)
   );

   // ---------------- DW=64 instance ----------------
   logic        rst64 = 1'b1;
   logic        len64 = 1'b1;
   logic        v64 = 1'b0;
   logic        rdy64;
   logic [31:0] a64 = 32'd0;
   logic [63:0] d64 = 64'd0;
   logic        l64 = 1'b0;
   logic [31:0] adr64;
   logic [63:0] dat64;
   logic [7:0]  sel64;
   logic        we64, cyc64, stb64;
   logic [2:0]  cti64;
   logic [1:0]  bte64;
   logic        ack64 = 1'b0;
   logic        err64 = 1'b0;
   logic [2:0]  rsto64;
   logic        done64, erro64;
   logic [31:0] cnt64;

   wb_mem_preloader #(.DW(64), .AW(32), .N_RST(3), .RST_HOLD(3), .STAGGER(2), .TIMEOUT(0)) dut64 (
      .wb_clk_i(clk), .wb_rst_i(rst64), .load_en_i(len64),
      .s_valid_i(v64), .s_ready_o(rdy64), .s_addr_i(a64), .s_data_i(d64), .s_last_i(l64),
      .wbm_adr_o(adr64), .wbm_dat_o(dat64), .wbm_sel_o(sel64), .wbm_we_o(we64),
      .wbm_cyc_o(cyc64), .wbm_stb_o(stb64), .wbm_cti_o(cti64), .wbm_bte_o(bte64),
      .wbm_ack_i(ack64), .wbm_err_i(err64),
      .rst_o(rsto64), .done_o(done64), .err_o(erro64), .word_cnt_o(cnt64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // zero-wait slave + scoreboard monitor for the DW=32 instance
   int          wr_seen = 0;
   int          err_on  = 0;
   bit          noack   = 1'b0;
   logic [31:0] mem [0:63];

   always @(negedge clk) begin
      exp_t e;
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      if (wbm_cyc && wbm_stb && !noack) begin
         wr_seen++;
         if (wr_seen == err_on) wbm_err = 1'b1;
         else begin
            wbm_ack = 1'b1;
            mem[wbm_adr[7:2]] = wbm_dat;
         end
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual_adr=0x%0h expected=no_write", wbm_adr);
         end else begin
            e = exp_q.pop_front();
            chk("wr_adr", {32'd0, wbm_adr}, {32'd0, e.adr});
            chk("wr_dat", {32'd0, wbm_dat}, e.dat);
            chk("wr_sel", {60'd0, wbm_sel}, {56'd0, e.sel});
            chk("wr_we", {63'd0, wbm_we}, 64'd1);
            chk("wr_ready_low", {63'd0, s_ready}, 64'd0);
            chk("wr_cti_bte", {59'd0, wbm_cti, wbm_bte}, 64'd0);
         end
      end
      if (wb_rst) wr_seen = 0;
   end

   // zero-wait slave + scoreboard monitor for the DW=64 instance
   always @(negedge clk) begin
      exp_t e;
      ack64 = 1'b0;
      if (cyc64 && stb64) begin
         ack64 = 1'b1;
         if (exp64_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write64 actual_adr=0x%0h expected=no_write", adr64);
         end else begin
            e = exp64_q.pop_front();
            chk("wr64_adr", {32'd0, adr64}, {32'd0, e.adr});
            chk("wr64_dat", dat64, e.dat);
            chk("wr64_sel", {56'd0, sel64}, {56'd0, e.sel});
            chk("wr64_we_cti_bte", {58'd0, we64, cti64, bte64}, {58'd0, 6'b100000});
         end
      end
   end

   task automatic do_reset(input logic le);
      load_en = le;
      s_valid = 1'b0;
      wb_rst  = 1'b1;
      repeat (3) @(posedge clk);
      #1 wb_rst = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic l,
                       input logic [31:0] exp_a, input bit push);
      bit rdy;
      bit accepted = 1'b0;
      if (push) exp_q.push_back('{adr: exp_a, dat: {32'd0, d}, sel: 8'h0F});
      s_addr = a; s_data = d; s_last = l; s_valid = 1'b1;
      for (int n = 0; n < 100 && !accepted; n++) begin
         @(negedge clk);
         rdy = s_ready;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1'b1;
      end
      s_valid = 1'b0;
      if (!accepted) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not_accepted expected=accepted addr=0x%0h", a);
      end
   endtask

   task automatic send64(input logic [31:0] a, input logic [63:0] d, input logic l,
                         input logic [31:0] exp_a);
      bit rdy;
      bit accepted = 1'b0;
      exp64_q.push_back('{adr: exp_a, dat: d, sel: 8'hFF});
      a64 = a; d64 = d; l64 = l; v64 = 1'b1;
      for (int n = 0; n < 100 && !accepted; n++) begin
         @(negedge clk);
         rdy = rdy64;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1'b1;
      end
      v64 = 1'b0;
      if (!accepted) begin
         checks++;
         failures++;
         $display("FAIL accept64_timeout actual=not_accepted expected=accepted addr=0x%0h", a);
      end
   endtask

   task automatic wait_done(input string name);
      for (int n = 0; n < 300 && !done; n++) @(negedge clk);
      chk(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      int stb_cnt;
      int err_at;

      // reset state
      @(posedge clk);
      @(negedge clk);
      chk("rst_bus", {59'd0, wbm_cyc, wbm_stb, wbm_we, wbm_cti == 3'b000, wbm_bte == 2'b00}, 64'd3);
      chk("rst_adr_dat_sel", {wbm_adr, wbm_dat | {28'd0, wbm_sel}}, 64'd0);
      chk("rst_outs", {58'd0, rst_o, done, err_o, s_ready, wcnt != 32'd0}, {58'd0, 6'b110000});

      // test 1: no load, staggered release at cycles 51 and 55, done at 56
      do_reset(1'b0);
      for (int n = 0; n <= 60; n++) begin
         @(negedge clk);
         chk($sformatf("t1_done_rst_c%0d", n), {61'd0, done, rst_o},
             {61'd0, n >= 56, n < 55, n < 51});
      end
      chk("t1_wcnt", {32'd0, wcnt}, 64'd0);

      // test 2: four aligned words
      do_reset(1'b1);
      send(32'h0, 32'hA0, 1'b0, 32'h0, 1'b1);
      send(32'h4, 32'hA1, 1'b0, 32'h4, 1'b1);
      send(32'h8, 32'hA2, 1'b0, 32'h8, 1'b1);
      send(32'hC, 32'hA3, 1'b1, 32'hC, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("t2_rst_held", {62'd0, rst_o}, 64'd3);
      chk("t2_wcnt", {32'd0, wcnt}, 64'd4);
      wait_done("t2_done");
      chk("t2_mem", {mem[0][7:0], mem[1][7:0], mem[2][7:0], mem[3][7:0]}, 64'hA0A1A2A3);
      chk("t2_rst_released", {62'd0, rst_o}, 64'd0);
      chk("t2_sb_empty", exp_q.size(), 64'd0);

      // test 3: unaligned address is aligned down
      do_reset(1'b1);
      send(32'h13, 32'hDEADBEEF, 1'b1, 32'h10, 1'b1);
      repeat (3) @(negedge clk);
      chk("t3_wcnt", {32'd0, wcnt}, 64'd1);
      chk("t3_mem", {32'd0, mem[4]}, 64'hDEADBEEF);

      // test 4: bus error on 2nd word
      err_on = 2;
      do_reset(1'b1);
      send(32'h20, 32'h11, 1'b0, 32'h20, 1'b1);
      send(32'h24, 32'h22, 1'b0, 32'h24, 1'b1);
      @(negedge clk);
      chk("t4_err_not_yet", {63'd0, err_o}, 64'd0);
      @(negedge clk);
      chk("t4_err_set", {63'd0, err_o}, 64'd1);
      chk("t4_cyc_low", {62'd0, wbm_cyc, wbm_stb}, 64'd0);
      chk("t4_wcnt", {32'd0, wcnt}, 64'd1);
      chk("t4_rst_done", {61'd0, rst_o, done}, 64'd6);
      s_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4_sticky", {61'd0, s_ready, err_o, done}, 64'd2);
      s_valid = 1'b0;
      err_on = 0;

      // test 5: slave never acks, TIMEOUT=8
      noack = 1'b1;
      do_reset(1'b1);
      send(32'h40, 32'h55, 1'b1, 32'h40, 1'b0);
      stb_cnt = 0;
      err_at = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (wbm_stb) stb_cnt++;
         if (err_o && err_at == 0) err_at = k;
      end
      chk("t5_stb_cycles", stb_cnt, 64'd8);
      chk("t5_err_cycle", err_at, 64'd9);
      chk("t5_cyc_low", {63'd0, wbm_cyc}, 64'd0);
      noack = 1'b0;

      // test 6: reset during WRITE of word 3, then reload
      do_reset(1'b1);
      send(32'h0, 32'hB0, 1'b0, 32'h0, 1'b1);
      send(32'h4, 32'hB1, 1'b0, 32'h4, 1'b1);
      send(32'h8, 32'hB2, 1'b0, 32'h8, 1'b1);
      wb_rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_cyc_low", {62'd0, wbm_cyc, wbm_stb}, 64'd0);
      chk("t6_wcnt", {32'd0, wcnt}, 64'd0);
      chk("t6_rst_ready", {61'd0, rst_o, s_ready}, 64'd6);
      @(posedge clk);
      #1 wb_rst = 1'b0;
      send(32'h30, 32'hC0, 1'b0, 32'h30, 1'b1);
      send(32'h34, 32'hC1, 1'b1, 32'h34, 1'b1);
      wait_done("t6_done");
      chk("t6_mem", {mem[12], mem[13]}, {32'hC0, 32'hC1});
      chk("t6_wcnt2", {32'd0, wcnt}, 64'd2);
      chk("t6_sb_empty", exp_q.size(), 64'd0);

      // test 7: DW=64 instance
      repeat (2) @(posedge clk);
      #1 rst64 = 1'b0;
      send64(32'h2D, 64'h1122334455667788, 1'b0, 32'h28);
      send64(32'h37, 64'h99AABBCCDDEEFF00, 1'b1, 32'h30);
      for (int n = 0; n < 100 && !done64; n++) @(negedge clk);
      chk("t7_done64", {63'd0, done64}, 64'd1);
      chk("t7_cnt64", {32'd0, cnt64}, 64'd2);
      chk("t7_rst64", {60'd0, rsto64, erro64}, 64'd0);
      chk("t7_sb_empty", exp64_q.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wb_mem_preloader.md
Name: wb_mem_preloader

Overview:
- Synthesizable successor to backdoor ELF loading in the SoC testbench.
- Accepts a stream of (address, data) words and writes them into system memory as a Wishbone master. The source can be a bench streamer, a JTAG/UART debug bridge or a boot ROM.
- Holds CPU and peripheral resets asserted until loading completes, then releases N_RST reset channels in a staggered sequence.
- Generalised in data width, reset channel count, hold/stagger timing and bus timeout; it also detects bus errors.

Parameters:
- DW, 32, data width in bits; multiple of 8, 8..128.
- AW, 32, Wishbone address width.
- N_RST, 2, number of staggered reset outputs, 1..8.
- RST_HOLD, 50, cycles from end of load to release of rst_o[0].
- STAGGER, 4, cycles between release of rst_o[k] and rst_o[k+1].
- TIMEOUT, 255, maximum cycles with stb high and no ack/err before error; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- load_en_i  in  1  1 = wait for a stream; 0 = skip loading (the "no ELF" case).
- s_valid_i  in  1  stream word valid.
- s_ready_o  out  1  stream word accepted when s_valid_i & s_ready_o.
- s_addr_i  in  AW  byte address of the word.
- s_data_i  in  DW  word data.
- s_last_i  in  1  final word of the image.
- wbm_adr_o  out  AW  bus address.
- wbm_dat_o  out  DW  bus write data.
- wbm_sel_o  out  DW/8  byte selects.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type, constant 3'b000.
- wbm_bte_o  out  2  burst type, constant 2'b00.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.
- rst_o  out  N_RST  per-channel reset, active high.
- done_o  out  1  all resets released.
- err_o  out  1  sticky load error.
- word_cnt_o  out  32  words successfully written.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge) forces:
  - state to IDLE
  - all wbm_* control outputs and wbm_adr_o/wbm_dat_o to 0
  - wbm_sel_o to 0
  - rst_o to all ones
  - done_o, err_o and word_cnt_o to 0
  - s_ready_o to 0 while wb_rst_i is high.
- Reset mid-operation abandons any bus cycle: cyc/stb drop the next cycle and resets re-assert.
- State IDLE:
  - s_ready_o = load_en_i.
  - On s_valid_i & s_ready_o at edge t: capture addr, data and last; go to WRITE.
  - wbm_cyc_o, wbm_stb_o and wbm_we_o are high from cycle t+1.
  - If load_en_i=0, go to HOLD without accepting anything.
- Address and data formation:
  - wbm_adr_o = s_addr_i with the low log2(DW/8) bits forced to 0.
  - wbm_sel_o = all ones.
- State WRITE:
  - s_ready_o=0; cyc, stb and we held with stable address and data.
  - On wbm_ack_i: drop cyc/stb/we the next cycle and increment word_cnt_o. Go to HOLD if the captured last=1, otherwise go to IDLE.
  - Maximum throughput is one word per 2 cycles with a zero-wait-state slave.
  - On wbm_err_i, or when the timeout counter reaches TIMEOUT: drop cyc/stb, set err_o, go to ERROR. word_cnt_o is not incremented.
  - If ack and err are high in the same cycle, err wins.
- State HOLD:
  - A counter runs from 0.
  - rst_o[k] deasserts when the counter reaches RST_HOLD + k*STAGGER.
  - When all channels are released, go to DONE.
  - If RST_HOLD=0, rst_o[0] deasserts on the first HOLD cycle.
- State DONE:
  - done_o=1, rst_o all zero, s_ready_o=0.
  - Further stream words are ignored. Only wb_rst_i leaves DONE.
- State ERROR:
  - err_o=1, rst_o all ones, done_o=0, s_ready_o=0.
  - Only wb_rst_i leaves ERROR.
- Width rules:
  - word_cnt_o saturates at 32'hFFFF_FFFF.
  - The HOLD counter is wide enough for RST_HOLD + (N_RST-1)*STAGGER.
  - The timeout counter is ceil(log2(TIMEOUT+1)) bits and clears on every accepted word.

Test Plan:
- load_en_i=0, RST_HOLD=50, STAGGER=4, N_RST=2, reset released at cycle 0 -> rst_o[0] low at cycle 51 and rst_o[1] at cycle 55; done_o=1; word_cnt_o=0; no wbm_cyc_o ever.
- Stream 4 words to addr 0x0, 0x4, 0x8, 0xC (data 0xA0..0xA3, last on the 4th) into a zero-wait memory model -> memory holds A0..A3; 4 writes with sel=4'hF; word_cnt_o=4; s_ready_o low during each WRITE; resets release afterwards.
- Unaligned addr 0x13 with data 0xDEADBEEF, last=1 -> write appears at wbm_adr_o=0x10.
- Slave asserts wbm_err_i on the 2nd word -> err_o=1 the next cycle; word_cnt_o=1; rst_o stays 2'b11; done_o=0; s_ready_o=0 until wb_rst_i.
- Slave never acks with TIMEOUT=8 -> err_o sets after 8 cycles of stb; cyc drops.
- Assert wb_rst_i during WRITE of word 3 -> cyc/stb low the next cycle; word_cnt_o=0; rst_o all ones; a new stream loads correctly after reset. Repeat with DW=64: 8-bit sel all ones, address low 3 bits zeroed.
